// File: rtl/gx4000_periph_arb_if.sv
// rtl/gx4000_periph_arb_if.sv - requester and peripheral-bus signals of the GX4000 peripheral arbiter
interface gx4000_periph_arb_if;
    logic        enable;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [7:0]  bus_data;
    logic [1:0]  bus_sel;
    logic        bus_strobe;
    logic        bus_ack;
    logic        busy;

    modport master (
        input  enable, req, req_data, bus_ack,
        output gnt, done, err, bus_data, bus_sel, bus_strobe, busy
    );

    modport slave (
        output enable, req, req_data, bus_ack,
        input  gnt, done, err, bus_data, bus_sel, bus_strobe, busy
    );
endinterface

// File: rtl/gx4000_periph_arb.sv
// rtl/gx4000_periph_arb.sv - round-robin strobe-bus arbiter for printer/RS232/Playcity; ack timeout under GX4000_ARB_TIMEOUT_EN
module gx4000_periph_arb #(
    parameter int STROBE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    gx4000_periph_arb_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_WAIT_ACK, S_RELEASE
    } state_t;

    localparam logic [7:0] STRB_LOAD = 8'(STROBE_CYCLES);

    state_t      state, state_nxt;
    logic [1:0]  last_owner, last_owner_nxt;
    logic [1:0]  sel_q, sel_nxt;
    logic [7:0]  data_q, data_nxt;
    logic [7:0]  strb_cnt, strb_cnt_nxt;
    logic        ack_seen, ack_seen_nxt;
    logic        fail_q, fail_nxt;
    logic [1:0]  cand0, cand1, win;
    logic [7:0]  win_byte;
    logic [2:0]  owner_oh;

`ifdef GX4000_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] to_cnt, to_cnt_nxt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search starts just after the previous owner; the previous owner is tried last.
    always_comb begin
        cand0 = rr_next(last_owner);
        cand1 = rr_next(cand0);
        if (bus.req[cand0])      win = cand0;
        else if (bus.req[cand1]) win = cand1;
        else                     win = last_owner;
        case (win)
            2'd1:    win_byte = bus.req_data[15:8];
            2'd2:    win_byte = bus.req_data[23:16];
            default: win_byte = bus.req_data[7:0];
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_owner <= 2'd2;
            sel_q      <= 2'd0;
            data_q     <= 8'd0;
            strb_cnt   <= 8'd0;
            ack_seen   <= 1'b0;
            fail_q     <= 1'b0;
`ifdef GX4000_ARB_TIMEOUT_EN
            to_cnt     <= 16'd0;
`endif
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            sel_q      <= sel_nxt;
            data_q     <= data_nxt;
            strb_cnt   <= strb_cnt_nxt;
            ack_seen   <= ack_seen_nxt;
            fail_q     <= fail_nxt;
`ifdef GX4000_ARB_TIMEOUT_EN
            to_cnt     <= to_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        sel_nxt        = sel_q;
        data_nxt       = data_q;
        strb_cnt_nxt   = strb_cnt;
        ack_seen_nxt   = ack_seen;
        fail_nxt       = fail_q;
`ifdef GX4000_ARB_TIMEOUT_EN
        to_cnt_nxt     = to_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (bus.enable && (bus.req != 3'b000)) begin
                    sel_nxt   = win;
                    data_nxt  = win_byte;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                strb_cnt_nxt = STRB_LOAD;
                fail_nxt     = 1'b0;
                state_nxt    = S_STROBE;
            end
            S_STROBE: begin
                if (bus.bus_ack) ack_seen_nxt = 1'b1;
                if (strb_cnt <= 8'd1) state_nxt = S_WAIT_ACK;
                else                  strb_cnt_nxt = strb_cnt - 8'd1;
            end
            S_WAIT_ACK: begin
                if (ack_seen || bus.bus_ack) begin
                    fail_nxt  = 1'b0;
                    state_nxt = S_RELEASE;
                end
`ifdef GX4000_ARB_TIMEOUT_EN
                else if (to_cnt == TO_LIMIT) begin
                    fail_nxt  = 1'b1;
                    state_nxt = S_RELEASE;
                end else begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
`endif
            end
            S_RELEASE: begin
                last_owner_nxt = sel_q;
                ack_seen_nxt   = 1'b0;
                strb_cnt_nxt   = 8'd0;
                fail_nxt       = 1'b0;
`ifdef GX4000_ARB_TIMEOUT_EN
                to_cnt_nxt     = 16'd0;
`endif
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode registered state only, so async reset clears them at once.
    assign owner_oh       = 3'b001 << sel_q;
    assign bus.gnt        = (state == S_SETUP) ? owner_oh : 3'b000;
    assign bus.done       = (state == S_RELEASE && !fail_q) ? owner_oh : 3'b000;
`ifdef GX4000_ARB_TIMEOUT_EN
    assign bus.err        = (state == S_RELEASE && fail_q) ? owner_oh : 3'b000;
`else
    assign bus.err        = 3'b000;
`endif
    assign bus.bus_data   = data_q;
    assign bus.bus_sel    = sel_q;
    assign bus.bus_strobe = (state == S_STROBE);
    assign bus.busy       = (state != S_IDLE);
endmodule

// File: doc/gx4000_periph_arb.md
# gx4000_periph_arb

Arbiter and bus sequencer that shares the single external peripheral strobe bus between the three Plus/GX4000 peripheral requesters: printer (0), RS232 (1) and Playcity (2). Each requester presents a byte and a request. The block grants one requester at a time in round-robin order and drives a timed strobe on the shared bus. It waits for the peripheral's acknowledge and reports completion or timeout back to the requester. It sits between the GX4000 I/O register block and the external peripheral pins.

## Interface
Parameters:
- STROBE_CYCLES, 4, cycles bus_strobe is held high (1..255)
- TIMEOUT_CYCLES, 1023, max cycles spent in WAIT_ACK before abort (1..65535)

Ports:
- clk_sys  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  gx4000_mode OR plus_mode; gates new grants only
- req  in  3  per-requester request, level, held until gnt
- req_data  in  24  byte per requester: [7:0]=req0, [15:8]=req1, [23:16]=req2
- gnt  out  3  one-hot, 1-cycle pulse: request accepted, req_data sampled
- done  out  3  one-hot, 1-cycle pulse: transfer acknowledged
- err  out  3  one-hot, 1-cycle pulse: transfer timed out
- bus_data  out  8  latched byte of current owner
- bus_sel  out  2  current owner index (0..2)
- bus_strobe  out  1  active-high strobe
- bus_ack  in  1  peripheral acknowledge, level
- busy  out  1  high whenever FSM not in IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, WAIT_ACK, RELEASE.
- IDLE: if enable && |req, pick winner by round robin, starting at (last_owner+1) mod 3. Latch req_data byte into bus_data, winner into bus_sel, and go to SETUP. If enable is low or no request, stay in IDLE.
- SETUP: gnt[owner]=1 for this one cycle; bus_data/bus_sel stable; strobe low.
- STROBE: bus_strobe=1 for exactly STROBE_CYCLES cycles (8-bit down-counter), then go to WAIT_ACK.
- bus_ack is sampled in every STROBE cycle. A high sample sets ack_seen.
- WAIT_ACK: if ack_seen || bus_ack, go to RELEASE with ok. Otherwise increment the 16-bit timeout counter. At count == TIMEOUT_CYCLES, go to RELEASE with fail.
- RELEASE: pulse done[owner] (ok) or err[owner] (fail); update last_owner=owner; clear ack_seen and counters; go to IDLE.
- Requesters must drop req no later than the cycle after gnt. req is not sampled outside IDLE.
- enable falling mid-transfer does not abort; the transfer completes normally.
- bus_data/bus_sel hold their value after RELEASE until the next grant.
- Reset: state=IDLE, last_owner=2 (so requester 0 wins first), and all outputs 0.

## Timing
- req sampled high in IDLE at edge N → gnt high during cycle N+1 (SETUP).
- bus_strobe high during cycles N+2 .. N+1+STROBE_CYCLES.
- With ack already high or seen during strobe: WAIT_ACK occupies 1 cycle and done pulses 2 cycles after the last strobe cycle. Minimum transfer is STROBE_CYCLES+3 cycles of busy.
- Timeout: err pulses in the RELEASE cycle, TIMEOUT_CYCLES+1 cycles after WAIT_ACK entry.
- Back-to-back: the next grant can be sampled on the edge leaving RELEASE→IDLE plus one, so IDLE always lasts at least 1 cycle.
- Simultaneous requests: exactly one gnt per transfer. Order is strictly rotating, and no requester is starved.
- reset_n low at any time forces IDLE and clears the outputs immediately (async), including mid-strobe.

## Configuration
- GX4000_ARB_TIMEOUT_EN defined: timeout counter present; behaviour as above.
- Not defined: no counter is implemented, WAIT_ACK waits indefinitely for ack, err is tied to 3'b000, and TIMEOUT_CYCLES is unused.

## Test plan
- Single request: req=3'b001, req_data[7:0]=8'hA5, ack tied high → gnt=001 one cycle, bus_data=A5, bus_sel=0, strobe 4 cycles, done=001; busy for 7 cycles.
- Round robin: req=3'b111 held, reassert after each done → grant order 0,1,2,0, with bus_data matching each byte.
- Early ack: 1-cycle ack pulse in the 2nd strobe cycle → done still pulses; WAIT_ACK lasts 1 cycle; no err.
- Timeout (macro on, TIMEOUT_CYCLES=16): ack held low → err=owner exactly 17 cycles after WAIT_ACK entry, no done; the next requester is then served. With the macro off, busy stays high indefinitely.
- Reset mid-transfer: reset_n low during the 3rd strobe cycle → bus_strobe, busy, gnt, done and err are 0 immediately. After release, requester 0 wins first.
- Enable gating: enable=0, req=3'b010 → no gnt. enable falls during STROBE → transfer completes with done, and no further grant follows.
